// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: radix-2 SDF stage sequencer; in_valid/in_last in, FIFO push/pop, mux selects, twiddle address, delayed out_valid, frame count and sticky err out
module sdf_stage_ctrl #(
  parameter int DEPTH    = 4,
  parameter int TW_DEPTH = 8,
  parameter int TW_STEP  = TW_DEPTH / DEPTH,
  parameter int MUL_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        push,
  output logic                        pop,
  output logic                        sel1,
  output logic                        sel2,
  output logic [$clog2(TW_DEPTH)-1:0] tw_addr,
  output logic                        out_valid,
  output logic                        frame_done,
  output logic [15:0]                 frame_cnt,
  output logic                        busy,
  output logic                        err
);
  localparam int IW = $clog2(DEPTH);
  localparam int AW = $clog2(TW_DEPTH);
  typedef enum logic [1:0] {PRIME, BFLY, FILL, FLUSH} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [MUL_LAT-1:0] pipe_q, pipe_d;
  logic [15:0] frame_cnt_q;
  logic err_q, err_d;
  logic flush, beat, last, out_pre;
  assign flush      = state_q == FLUSH;
  assign in_ready   = !flush;
  assign beat       = flush | in_valid;
  assign last       = idx_q == IW'(DEPTH - 1);
  assign push       = beat & !flush;
  assign out_pre    = beat & (state_q != PRIME);
  assign pop        = out_pre;
  assign sel1       = state_q == BFLY;
  assign sel2       = (state_q == PRIME) || (state_q == BFLY);
  assign tw_addr    = sel2 ? '0 : AW'(32'(idx_q) * 32'(TW_STEP));
  assign frame_done = beat & last & (state_q == BFLY);
  assign busy       = (state_q != PRIME) || (idx_q != '0);
  assign out_valid  = pipe_q[MUL_LAT-1];
  assign frame_cnt  = frame_cnt_q;
  assign err        = err_q;
  always_comb begin
    idx_d   = beat ? idx_q + IW'(1) : idx_q;
    err_d   = err_q | (beat & in_last & !frame_done);
    pipe_d  = MUL_LAT'({pipe_q, out_pre});
    state_d = !(beat & last)   ? state_q :
              state_q == PRIME ? BFLY :
              state_q == BFLY  ? (in_last ? FLUSH : FILL) :
              state_q == FILL  ? BFLY : PRIME;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PRIME;
      idx_q       <= '0;
      pipe_q      <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pipe_q      <= pipe_d;
      frame_cnt_q <= frame_cnt_q + 16'(frame_done);
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: directed stimulus with a per-cycle expected-output scoreboard checked by a separate monitor
module tb_sdf_stage_ctrl;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic in_ready, push, pop, sel1, sel2, out_valid, frame_done, busy, err;
  logic [2:0] tw_addr;
  logic [15:0] frame_cnt;
  typedef struct {logic [11:0] v; logic [15:0] fc; int n;} exp_t;
  exp_t q[$];
  int n_cyc = 0, checks = 0, passed = 0;
  sdf_stage_ctrl #(.DEPTH(4), .TW_DEPTH(8), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .push(push), .pop(pop), .sel1(sel1), .sel2(sel2),
    .tw_addr(tw_addr), .out_valid(out_valid), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin : mon
    exp_t e;
    logic [11:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {in_ready, push, pop, sel1, sel2, tw_addr, out_valid, frame_done, busy, err};
      checks++;
      if (got === e.v) passed++;
      else $display("FAIL ctl cycle %0d: got %b required %b (ir pu po s1 s2 tw ov fd bz er)", e.n, got, e.v);
      checks++;
      if (frame_cnt === e.fc) passed++;
      else $display("FAIL frame_cnt cycle %0d: got %0d required %0d", e.n, frame_cnt, e.fc);
    end
  end
  task automatic step(input logic iv, input logic il, input logic r, input logic [11:0] e, input logic [15:0] fc);
    in_valid = iv;
    in_last  = il;
    rst      = r;
    q.push_back('{v: e, fc: fc, n: n_cyc});
    n_cyc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    // reset held, in_valid low: reset-state outputs
    repeat (3) step(0, 0, 1, 12'b1_0_0_0_1_000_0_0_0_0, 0);
    // one frame: 4 prime, 4 butterfly (last), 4 flush
    step(1, 0, 0, 12'b1_1_0_0_1_000_0_0_0_0, 0);
    repeat (3) step(1, 0, 0, 12'b1_1_0_0_1_000_0_0_1_0, 0);
    step(1, 0, 0, 12'b1_1_1_1_1_000_0_0_1_0, 0);
    repeat (2) step(1, 0, 0, 12'b1_1_1_1_1_000_1_0_1_0, 0);
    step(1, 1, 0, 12'b1_1_1_1_1_000_1_1_1_0, 0);
    step(0, 0, 0, 12'b0_0_1_0_0_000_1_0_1_0, 1);
    step(0, 0, 0, 12'b0_0_1_0_0_010_1_0_1_0, 1);
    step(0, 0, 0, 12'b0_0_1_0_0_100_1_0_1_0, 1);
    step(0, 0, 0, 12'b0_0_1_0_0_110_1_0_1_0, 1);
    step(0, 0, 0, 12'b1_0_0_0_1_000_1_0_0_0, 1);
    step(0, 0, 0, 12'b1_0_0_0_1_000_0_0_0_0, 1);
    step(0, 0, 1, 12'b1_0_0_0_1_000_0_0_0_0, 1);
    // two frames: prime, bfly, fill, bfly (last), flush
    step(1, 0, 0, 12'b1_1_0_0_1_000_0_0_0_0, 0);
    repeat (3) step(1, 0, 0, 12'b1_1_0_0_1_000_0_0_1_0, 0);
    step(1, 0, 0, 12'b1_1_1_1_1_000_0_0_1_0, 0);
    repeat (2) step(1, 0, 0, 12'b1_1_1_1_1_000_1_0_1_0, 0);
    step(1, 0, 0, 12'b1_1_1_1_1_000_1_1_1_0, 0);
    step(1, 0, 0, 12'b1_1_1_0_0_000_1_0_1_0, 1);
    step(1, 0, 0, 12'b1_1_1_0_0_010_1_0_1_0, 1);
    step(1, 0, 0, 12'b1_1_1_0_0_100_1_0_1_0, 1);
    step(1, 0, 0, 12'b1_1_1_0_0_110_1_0_1_0, 1);
    repeat (3) step(1, 0, 0, 12'b1_1_1_1_1_000_1_0_1_0, 1);
    step(1, 1, 0, 12'b1_1_1_1_1_000_1_1_1_0, 1);
    step(0, 0, 0, 12'b0_0_1_0_0_000_1_0_1_0, 2);
    step(0, 0, 0, 12'b0_0_1_0_0_010_1_0_1_0, 2);
    step(0, 0, 0, 12'b0_0_1_0_0_100_1_0_1_0, 2);
    step(0, 0, 0, 12'b0_0_1_0_0_110_1_0_1_0, 2);
    step(0, 0, 0, 12'b1_0_0_0_1_000_1_0_0_0, 2);
    step(0, 0, 0, 12'b1_0_0_0_1_000_0_0_0_0, 2);
    step(0, 0, 1, 12'b1_0_0_0_1_000_0_0_0_0, 2);
    // 2-cycle stall at butterfly idx 2
    step(1, 0, 0, 12'b1_1_0_0_1_000_0_0_0_0, 0);
    repeat (3) step(1, 0, 0, 12'b1_1_0_0_1_000_0_0_1_0, 0);
    step(1, 0, 0, 12'b1_1_1_1_1_000_0_0_1_0, 0);
    step(1, 0, 0, 12'b1_1_1_1_1_000_1_0_1_0, 0);
    step(0, 0, 0, 12'b1_0_0_1_1_000_1_0_1_0, 0);
    step(0, 0, 0, 12'b1_0_0_1_1_000_0_0_1_0, 0);
    step(1, 0, 0, 12'b1_1_1_1_1_000_0_0_1_0, 0);
    step(1, 1, 0, 12'b1_1_1_1_1_000_1_1_1_0, 0);
    step(0, 0, 0, 12'b0_0_1_0_0_000_1_0_1_0, 1);
    step(0, 0, 0, 12'b0_0_1_0_0_010_1_0_1_0, 1);
    step(0, 0, 0, 12'b0_0_1_0_0_100_1_0_1_0, 1);
    step(0, 0, 0, 12'b0_0_1_0_0_110_1_0_1_0, 1);
    step(0, 0, 0, 12'b1_0_0_0_1_000_1_0_0_0, 1);
    step(0, 0, 0, 12'b1_0_0_0_1_000_0_0_0_0, 1);
    step(0, 0, 1, 12'b1_0_0_0_1_000_0_0_0_0, 1);
    // stray in_last at prime idx 1 sets err; reset asserted at flush idx 2
    step(1, 0, 0, 12'b1_1_0_0_1_000_0_0_0_0, 0);
    step(1, 1, 0, 12'b1_1_0_0_1_000_0_0_1_0, 0);
    repeat (2) step(1, 0, 0, 12'b1_1_0_0_1_000_0_0_1_1, 0);
    step(1, 0, 0, 12'b1_1_1_1_1_000_0_0_1_1, 0);
    repeat (2) step(1, 0, 0, 12'b1_1_1_1_1_000_1_0_1_1, 0);
    step(1, 1, 0, 12'b1_1_1_1_1_000_1_1_1_1, 0);
    step(0, 0, 0, 12'b0_0_1_0_0_000_1_0_1_1, 1);
    step(0, 0, 0, 12'b0_0_1_0_0_010_1_0_1_1, 1);
    step(0, 0, 1, 12'b0_0_1_0_0_100_1_0_1_1, 1);
    repeat (2) step(0, 0, 0, 12'b1_0_0_0_1_000_0_0_0_0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 Parameter DEPTH, 4: delay-FIFO depth D = samples per half-frame; power of two, >= 2.
REQ-002 Parameter TW_DEPTH, 8: twiddle ROM depth; power of two, >= DEPTH.
REQ-003 Parameter TW_STEP, TW_DEPTH/DEPTH: twiddle address increment per sample.
REQ-004 Parameter MUL_LAT, 1: modular-multiplier latency in cycles, >= 1.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  upstream sample present.
REQ-009 in_last  in  1  qualifies the current beat as the last sample of the stream.
REQ-010 in_ready  out  1  controller accepts a sample this cycle.
REQ-011 push  out  1  FIFO write strobe.
REQ-012 pop  out  1  FIFO read strobe.
REQ-013 sel1  out  1  FIFO-input mux: 0 = incoming sample, 1 = butterfly difference.
REQ-014 sel2  out  1  multiplier-input mux: 0 = FIFO output, 1 = butterfly sum.
REQ-015 tw_addr  out  clog2(TW_DEPTH)  twiddle ROM address.
REQ-016 out_valid  out  1  multiplier output valid.
REQ-017 frame_done  out  1  one-cycle pulse on the final beat of each frame.
REQ-018 frame_cnt  out  16  completed-frame count.
REQ-019 busy  out  1  high unless the controller is in PRIME with idx = 0.
REQ-020 err  out  1  sticky protocol-error flag.

Function
REQ-021 beat = in_valid & in_ready in PRIME/BFLY/FILL; in FLUSH, beat = 1 every cycle.
REQ-022 idx is a clog2(DEPTH)-bit counter; it increments on every beat and holds otherwise.
REQ-023 States: PRIME, BFLY, FILL, FLUSH.
REQ-024 Transitions:
- PRIME, beat at idx = D-1 -> BFLY.
- BFLY, beat at idx = D-1 -> FLUSH if in_last, else -> FILL.
- FILL, beat at idx = D-1 -> BFLY.
- FLUSH, idx = D-1 -> PRIME.
- idx wraps to 0 on every transition.
REQ-025 PRIME: push = beat, pop = 0, sel1 = 0, sel2 = 1, tw_addr = 0, no output.
REQ-026 BFLY: push = pop = beat, sel1 = 1, sel2 = 1, tw_addr = 0.
REQ-027 FILL: push = pop = beat, sel1 = 0, sel2 = 0, tw_addr = idx*TW_STEP, truncated to width.
REQ-028 FLUSH: in_ready = 0, push = 0, pop = 1, sel1 = 0, sel2 = 0, tw_addr = idx*TW_STEP.
REQ-029 in_ready = 1 in PRIME, BFLY and FILL.
REQ-030 push, pop, in_ready and tw_addr are combinational from state, idx and in_valid; sel1 and sel2 depend on state only.
REQ-031 Output valid pipeline:
- out_pre = beat in BFLY, FILL or FLUSH.
- out_valid = out_pre delayed by exactly MUL_LAT cycles through a shift register.
REQ-032 Stall (in_valid = 0 outside FLUSH): push = pop = 0; state and idx hold; the pipeline keeps shifting.
REQ-033 frame_done pulses combinationally on the BFLY beat at idx = D-1; frame_cnt increments on the next edge and wraps 0xFFFF -> 0.
REQ-034 in_last on any beat other than the BFLY beat at idx = D-1 is ignored for sequencing and sets err; err stays 1 until reset.

Reset
REQ-035 On rst the following take effect at the next edge:
- state = PRIME, idx = 0.
- out_valid pipeline cleared; frame_cnt = 0; err = 0.
REQ-036 Resulting output values: in_ready = 1, push = pop = 0, sel1 = 0, sel2 = 1, tw_addr = 0, out_valid = 0, frame_done = 0, busy = 0.
REQ-037 Reset mid-frame discards all in-flight state; any pending out_valid bits are never emitted.

Verification
REQ-038 Apply rst, hold in_valid = 0 -> outputs match REQ-036 for every cycle.
REQ-039 D = 4, TW_DEPTH = 8, MUL_LAT = 1; 8 back-to-back beats, in_last on beat 8:
- beats 1-4: push only.
- beats 5-8: push = pop = 1, sel1 = sel2 = 1; frame_done on beat 8.
- then 4 FLUSH cycles: in_ready = 0, pop = 1, tw_addr = 0, 2, 4, 6.
- out_valid high for exactly 8 cycles, starting one cycle after beat 5.
- frame_cnt = 1.
REQ-040 16 back-to-back beats, in_last on beat 16:
- beats 9-12 in FILL, sel1 = sel2 = 0, tw_addr = 0, 2, 4, 6.
- frame_done pulses on beats 8 and 16; frame_cnt = 2 after FLUSH.
REQ-041 Drop in_valid for 2 cycles at BFLY idx = 2:
- push = pop = 0 and idx holds at 2 during the gap.
- out_valid shows a matching 2-cycle gap, one cycle later.
REQ-042 in_last on PRIME beat idx = 1 -> err = 1; the sequence continues unchanged into BFLY.
REQ-043 Assert rst at FLUSH idx = 2 -> the next cycle shows state PRIME, pop = 0, and no out_valid pulse.
